// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg - opcode and FSM state encodings for alu_pipe_param. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_CMB = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op_t'(op) == OP_SHL) || (op_t'(op) == OP_SHR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arith_core.sv
// +--------------------------------------------------------------------+
// | alu_arith_core - single-cycle add/sub/combine/logic with flags. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_arith_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_co,
  output logic             o_ovf
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    o_result = '0;
    o_co     = 1'b0;
    o_ovf    = 1'b0;
    case (op_t'(i_op))
      OP_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_co     = w_sum[WIDTH];
        o_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        // co high means no borrow, i.e. a >= b unsigned
        o_result = w_diff[WIDTH-1:0];
        o_co     = w_diff[WIDTH];
        o_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_CMB: o_result = {i_a[WIDTH-1:WIDTH/2], i_b[WIDTH/2-1:0]};
      OP_AND: o_result = i_a & i_b;
      OP_OR:  o_result = i_a | i_b;
      OP_XOR: o_result = i_a ^ i_b;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe_param.sv
// +--------------------------------------------------------------------+
// | alu_pipe_param - handshaked ALU with iterative 1-bit/cycle shifts. Rev 1.0 |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_pipe_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_co,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_result;
  logic [SHW-1:0]   r_cnt;
  logic             r_right;
  logic             r_co;
  logic             r_ovf;
  logic             r_zero;

  logic [WIDTH-1:0] w_core_result;
  logic             w_core_co;
  logic             w_core_ovf;
  logic             w_accept;
  logic             w_op_shift;
  logic [SHW-1:0]   w_amt;
  logic             w_shift_start;
  logic             w_last;
  logic [WIDTH-1:0] w_step;
  logic             w_step_out;

  alu_arith_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_result (w_core_result),
    .o_co     (w_core_co),
    .o_ovf    (w_core_ovf)
  );

  // Ready is forced low while reset is held, even though state already reads IDLE
  assign o_in_ready    = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready));
  assign w_accept      = i_in_valid && o_in_ready;
  assign w_op_shift    = is_shift(i_op);
  assign w_amt         = i_b[SHW-1:0];
  assign w_shift_start = w_accept && w_op_shift && (w_amt != '0);
  assign w_last        = (r_cnt == {{(SHW-1){1'b0}}, 1'b1});
  assign w_step        = r_right ? {1'b0, r_result[WIDTH-1:1]} : {r_result[WIDTH-2:0], 1'b0};
  assign w_step_out    = r_right ? r_result[0] : r_result[WIDTH-1];

  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_co        = r_co;
  assign o_ovf       = r_ovf;
  assign o_zero      = r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)                               w_next = w_shift_start ? S_SHIFT : S_DONE;
        else if ((r_state == S_DONE) && i_out_ready) w_next = S_IDLE;
      end
      S_SHIFT: if (w_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_result doubles as the shift accumulator; it is not visible while SHIFT holds out_valid low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_cnt    <= '0;
      r_right  <= 1'b0;
      r_co     <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept) begin
      r_right <= (op_t'(i_op) == OP_SHR);
      r_cnt   <= w_op_shift ? w_amt : '0;
      if (w_op_shift) begin
        r_result <= i_a;
        r_co     <= 1'b0;
        r_ovf    <= 1'b0;
        r_zero   <= (i_a == '0);
      end else begin
        r_result <= w_core_result;
        r_co     <= w_core_co;
        r_ovf    <= w_core_ovf;
        r_zero   <= (w_core_result == '0);
      end
    end else if (r_state == S_SHIFT) begin
      r_result <= w_step;
      r_co     <= w_step_out;
      r_cnt    <= r_cnt - 1'b1;
      r_zero   <= (w_step == '0);
    end
  end

endmodule

`default_nettype wire
